// File: rtl/c_alu_pkg.sv
// Shared types for the ALU arbiter: op encodings, FSM states and the
// request/response records that travel between arbiter and ALU.
package c_alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_AND  = 3'b001,
    ALU_OR   = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_XNOR = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    alu_op_e          op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             zero;
  } alu_rsp_t;

  function automatic alu_rsp_t mk_rsp(input logic [ALU_W-1:0] d);
    alu_rsp_t r;
    r.data = d;
    r.zero = (d == '0);
    return r;
  endfunction

endpackage

// File: rtl/c_alu_arbiter_if.sv
// Request/response bundle between the requesters and the shared ALU issue stage.
interface c_alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = $clog2(NREQ)
);
  logic                      stall;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_lock;
  logic [NREQ-1:0][2:0]      req_op;
  logic [NREQ-1:0][W-1:0]    req_a;
  logic [NREQ-1:0][W-1:0]    req_b;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           rsp_valid;
  logic [IDW-1:0]            rsp_id;
  logic [W-1:0]              rsp_data;
  logic                      rsp_zero;
  logic                      owner_locked;

  modport master (
    output stall, req_valid, req_lock, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, owner_locked
  );

  modport slave (
    input  stall, req_valid, req_lock, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, owner_locked
  );
endinterface

// File: rtl/C_ALU.sv
// 16-bit combinational ALU, eight logic/arith ops, no carry or overflow out.
module C_ALU
  import c_alu_pkg::*;
(
  input  alu_op_e          op_i,
  input  logic [ALU_W-1:0] in0_i,
  input  logic [ALU_W-1:0] in1_i,
  output logic [ALU_W-1:0] out_o
);
  always_comb begin
    out_o = '0;
    case (op_i)
      ALU_ADD:  out_o = in0_i + in1_i;
      ALU_AND:  out_o = in0_i & in1_i;
      ALU_OR:   out_o = in0_i | in1_i;
      ALU_XOR:  out_o = in0_i ^ in1_i;
      ALU_SUB:  out_o = in0_i - in1_i;
      ALU_NAND: out_o = ~(in0_i & in1_i);
      ALU_NOR:  out_o = ~(in0_i | in1_i);
      ALU_XNOR: out_o = ~(in0_i ^ in1_i);
    endcase
  end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i,
// wrapping modulo NREQ (also correct when NREQ is not a power of two).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  int             sum;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IDW'(sum);
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/c_alu_arbiter.sv
// Round-robin issue stage sharing one C_ALU among NREQ requesters, with an
// optional ownership lock and a registered one-cycle response.
module c_alu_arbiter
  import c_alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ALU_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst,
  c_alu_arbiter_if.slave  bus
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;

  alu_req_t        alu_req;
  logic [ALU_W-1:0] alu_out;
  alu_rsp_t        alu_rsp;

  logic [NREQ-1:0] rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [W-1:0]    rsp_data_q;
  logic            rsp_zero_q;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + IDW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Arbitration FSM. In LOCKED the owner bypasses the picker and the pointer
  // stays frozen until the owner releases or goes idle.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    gnt       = '0;
    gnt_idx   = pick_idx;
    gnt_any   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.stall && pick_any) begin
          gnt      = pick_gnt;
          gnt_any  = 1'b1;
          rr_ptr_d = wrap_inc(pick_idx);
          if (bus.req_lock[pick_idx]) begin
            state_d   = ST_LOCKED;
            lock_id_d = pick_idx;
          end
        end
      end
      ST_LOCKED: begin
        gnt_idx = lock_id_q;
        if (!bus.req_valid[lock_id_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_inc(lock_id_q);
        end else if (!bus.stall) begin
          gnt     = onehot(lock_id_q);
          gnt_any = 1'b1;
          if (!bus.req_lock[lock_id_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = wrap_inc(lock_id_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Idle ALU inputs are parked at ADD 0,0 so they do not toggle.
  always_comb begin
    alu_req.op = ALU_ADD;
    alu_req.a  = '0;
    alu_req.b  = '0;
    if (gnt_any) begin
      alu_req.op = alu_op_e'(bus.req_op[gnt_idx]);
      alu_req.a  = bus.req_a[gnt_idx];
      alu_req.b  = bus.req_b[gnt_idx];
    end
  end

  C_ALU u_alu (
    .op_i  (alu_req.op),
    .in0_i (alu_req.a),
    .in1_i (alu_req.b),
    .out_o (alu_out)
  );

  assign alu_rsp = mk_rsp(alu_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b1;
    end else if (gnt_any) begin
      rsp_valid_q <= gnt;
      rsp_id_q    <= gnt_idx;
      rsp_data_q  <= alu_rsp.data;
      rsp_zero_q  <= alu_rsp.zero;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  // Ready is forced low during reset so nothing is accepted while clearing.
  assign bus.req_ready    = rst ? '0 : gnt;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.owner_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_c_alu_arbiter.sv
// Directed bench for c_alu_arbiter: per-requester op queues, a scoreboard of
// expected responses, and grant-order checks against fixed sequences.
module tb_c_alu_arbiter;
  import c_alu_pkg::*;

  localparam int NREQ = 4;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        lock;
  } tb_req_t;

  typedef struct packed {
    logic [3:0]  v;
    logic [1:0]  id;
    logic [15:0] d;
    logic        z;
  } obs_t;

  typedef struct packed {
    obs_t e;
    obs_t o;
  } pair_t;

  typedef struct packed {
    logic [3:0] v;
    logic       lk;
  } gnt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  c_alu_arbiter_if #(.NREQ(NREQ), .W(16)) bus();
  c_alu_arbiter #(.NREQ(NREQ), .W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  tb_req_t         rq[NREQ][$];
  int              rd_idx[NREQ] = '{default: 0};
  int              flush_gen  = 0;
  int              flush_seen = 0;
  logic [NREQ-1:0] fire_q = '0;
  obs_t            exp_q[$];
  pair_t           chk_q[$];
  obs_t            rsp_hist[$];
  gnt_t            gnt_log[$];
  int              n_cmp = 0;
  int              n_err = 0;
  int              chk_rd = 0;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return a - b;
      3'd5:    return ~(a & b);
      3'd6:    return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // Requester model: present the head of each queue, advance on a handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (flush_seen != flush_gen) rd_idx[i] = rq[i].size();
      else if (fire_q[i]) rd_idx[i] = rd_idx[i] + 1;
      if (rd_idx[i] < rq[i].size()) begin
        bus.req_valid[i] = 1'b1;
        bus.req_lock[i]  = rq[i][rd_idx[i]].lock;
        bus.req_op[i]    = rq[i][rd_idx[i]].op;
        bus.req_a[i]     = rq[i][rd_idx[i]].a;
        bus.req_b[i]     = rq[i][rd_idx[i]].b;
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_lock[i]  = 1'b0;
        bus.req_op[i]    = 3'd0;
        bus.req_a[i]     = 16'h0;
        bus.req_b[i]     = 16'h0;
      end
    end
    flush_seen = flush_gen;
  end

  // Monitor: pair each response with the scoreboard head, log grants.
  always @(negedge clk) begin
    obs_t       o;
    obs_t       e;
    logic [1:0] idx;
    if (rst) begin
      exp_q.delete();
      fire_q = '0;
    end else begin
      o = '{v: bus.rsp_valid, id: bus.rsp_id, d: bus.rsp_data, z: bus.rsp_zero};
      if (bus.rsp_valid != '0) begin
        rsp_hist.push_back(o);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk_q.push_back('{e: e, o: o});
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_q.push_back('{e: e, o: o});
      end
      fire_q = bus.req_valid & bus.req_ready;
      if (fire_q != '0) begin
        gnt_log.push_back('{v: fire_q, lk: bus.owner_locked});
        idx = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) if (fire_q[i]) idx = 2'(i);
        e.v  = 4'b0001 << idx;
        e.id = idx;
        e.d  = ref_alu(bus.req_op[idx], bus.req_a[idx], bus.req_b[idx]);
        e.z  = (e.d == 16'h0);
        exp_q.push_back(e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic lock);
    tb_req_t r;
    r.op = op; r.a = a; r.b = b; r.lock = lock;
    rq[i].push_back(r);
  endtask

  task automatic drain_pairs();
    while (chk_rd < chk_q.size()) begin
      n_cmp++;
      assert (chk_q[chk_rd].o === chk_q[chk_rd].e) else begin
        n_err++;
        $error("FAIL rsp#%0d: got %h expected %h", chk_rd, chk_q[chk_rd].o, chk_q[chk_rd].e);
      end
      chk_rd++;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(posedge clk); #2;
      idle = 1'b1;
      for (int i = 0; i < NREQ; i++) if (rd_idx[i] < rq[i].size()) idle = 1'b0;
      if (exp_q.size() != 0) idle = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_drained"}, 32'(idle), 32'd1);
    drain_pairs();
  endtask

  task automatic chk_gnt(input string tag, input int k, input logic [3:0] v, input logic lk);
    gnt_t g;
    g = (k < gnt_log.size()) ? gnt_log[k] : 'x;
    chk(tag, 32'(g), 32'({v, lk}));
  endtask

  initial begin
    int gb;
    int hb;
    bit seen;
    bus.stall = 1'b0;
    rst = 1'b1;

    push(0, 3'd0, 16'h0001, 16'h0002, 1'b0);
    push(1, 3'd4, 16'h0005, 16'h0005, 1'b0);
    push(2, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
    push(3, 3'd6, 16'h0000, 16'h0000, 1'b0);
    push(0, 3'd3, 16'hA5A5, 16'hFFFF, 1'b0);
    push(1, 3'd1, 16'hF0F0, 16'h0FF0, 1'b0);
    push(2, 3'd2, 16'h1200, 16'h0034, 1'b0);
    push(3, 3'd5, 16'hFFFF, 16'hFFFF, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_locked", 32'(bus.owner_locked), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("post_rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("post_rst_rsp_zero", 32'(bus.rsp_zero), 32'h1);
    chk("post_rst_locked", 32'(bus.owner_locked), 32'h0);
    chk("first_ready", 32'(bus.req_ready), 32'h1);

    // Round robin with all four continuously valid
    wait_idle("rr");
    for (int k = 0; k < 8; k++) chk_gnt("rr_gnt", k, 4'b0001 << (k % 4), 1'b0);
    chk("rr_rsp_cnt", 32'(rsp_hist.size()), 32'd8);
    chk("sub_zero", 32'(rsp_hist[1]), 32'({4'b0010, 2'd1, 16'h0000, 1'b1}));
    chk("add_ovf", 32'(rsp_hist[2]), 32'({4'b0100, 2'd2, 16'h8000, 1'b0}));
    chk("nor_ffff", 32'(rsp_hist[3]), 32'({4'b1000, 2'd3, 16'hFFFF, 1'b0}));
    chk("nand_zero", 32'(rsp_hist[7]), 32'({4'b1000, 2'd3, 16'h0000, 1'b1}));

    // Move pointer to 2, then requester 2 locks for three ops
    gb = gnt_log.size();
    push(1, 3'd0, 16'h0010, 16'h0020, 1'b0);
    wait_idle("ptr");
    chk_gnt("ptr_gnt", gb, 4'b0010, 1'b0);

    gb = gnt_log.size();
    hb = rsp_hist.size();
    push(2, 3'd7, 16'h1234, 16'h1234, 1'b1);
    push(2, 3'd4, 16'h0000, 16'h0001, 1'b1);
    push(2, 3'd0, 16'hFFFF, 16'h0001, 1'b0);
    push(0, 3'd1, 16'h00FF, 16'h0F0F, 1'b0);
    push(1, 3'd2, 16'h0100, 16'h0001, 1'b0);
    push(3, 3'd3, 16'h5555, 16'hAAAA, 1'b0);
    wait_idle("lock");
    chk_gnt("lock_g0", gb + 0, 4'b0100, 1'b0);
    chk_gnt("lock_g1", gb + 1, 4'b0100, 1'b1);
    chk_gnt("lock_g2", gb + 2, 4'b0100, 1'b1);
    chk_gnt("lock_g3", gb + 3, 4'b1000, 1'b0);
    chk_gnt("lock_g4", gb + 4, 4'b0001, 1'b0);
    chk_gnt("lock_g5", gb + 5, 4'b0010, 1'b0);
    chk("sub_wrap", 32'(rsp_hist[hb + 1].d), 32'hFFFF);
    chk("add_wrap_zero", 32'({rsp_hist[hb + 2].d, rsp_hist[hb + 2].z}), 32'({16'h0000, 1'b1}));
    chk("lock_released", 32'(bus.owner_locked), 32'h0);

    // Stall for two cycles right after a grant to 3
    gb = gnt_log.size();
    push(0, 3'd0, 16'h0003, 16'h0004, 1'b0);
    push(1, 3'd0, 16'h0005, 16'h0006, 1'b0);
    push(3, 3'd0, 16'h0007, 16'h0008, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    bus.stall = 1'b1;
    #1;
    chk("stall_ready0", 32'(bus.req_ready), 32'h0);
    chk("stall_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 32'({4'b1000, 2'd3, 16'h000F}));
    @(posedge clk);
    #2;
    chk("stall_ready1", 32'(bus.req_ready), 32'h0);
    chk("stall_no_rsp", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #2;
    bus.stall = 1'b0;
    #1;
    chk("resume_ready", 32'(bus.req_ready), 32'h1);
    wait_idle("stall");
    chk_gnt("stall_g0", gb + 0, 4'b1000, 1'b0);
    chk_gnt("stall_g1", gb + 1, 4'b0001, 1'b0);
    chk_gnt("stall_g2", gb + 2, 4'b0010, 1'b0);

    // Reset in the cycle after a locked grant
    gb = gnt_log.size();
    push(2, 3'd0, 16'h0001, 16'h0001, 1'b1);
    push(2, 3'd0, 16'h0002, 16'h0002, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk); #2;
      seen = (gnt_log.size() > gb);
    end
    chk("rst_gnt_seen", 32'(seen), 32'd1);
    chk("pre_rst_locked", 32'(bus.owner_locked), 32'h1);
    chk("pre_rst_rsp", 32'(bus.rsp_valid), 32'h4);
    hb = rsp_hist.size();
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_locked", 32'(bus.owner_locked), 32'h0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    flush_gen++;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("no_rsp_after_rst", 32'(rsp_hist.size()), 32'(hb));
    chk("after_rst_locked", 32'(bus.owner_locked), 32'h0);
    chk("after_rst_data", 32'(bus.rsp_data), 32'h0);
    drain_pairs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
